// File: rtl/mem_burst_ctrl_if.sv
// Command, write-stream, read-stream and memory-request signals of mem_burst_ctrl.
// master = the burst controller, slave = its environment (memory, producer, consumer).
interface mem_burst_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH:0]   cmd_len;

    logic                  wd_valid;
    logic                  wd_ready;
    logic [WIDTH-1:0]      wd_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [WIDTH-1:0]      rd_data;

    logic                  done;
    logic                  err;

    logic                  mem_valid;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ready;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  mem_rdata, mem_ready,
        output cmd_ready, wd_ready, rd_valid, rd_data, done, err,
        output mem_valid, mem_wr_rd, mem_addr, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output rd_ready,
        output mem_rdata, mem_ready,
        input  cmd_ready, wd_ready, rd_valid, rd_data, done, err,
        input  mem_valid, mem_wr_rd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst master: turns one (addr, len, dir) command into single-word memory handshakes.
// Define MEM_BURST_WRAP_EN to let bursts wrap past DEPTH-1 instead of rejecting them.
module mem_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic              clk,
    input logic              rst,
    mem_burst_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_DATA,
        S_WR_MEM,
        S_RD_MEM,
        S_RD_OUT,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  reject;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] addr_inc;

`ifdef MEM_BURST_WRAP_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    assign reject   = (rem_q == '0);
    assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
`else
    localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH+2)'(DEPTH);

    logic [ADDR_WIDTH+1:0] end_sum;

    // Two guard bits so addr+len never truncates before the bound compare.
    assign end_sum  = {2'b00, addr_q} + {1'b0, rem_q};
    assign reject   = (rem_q == '0) || (end_sum > DEPTH_X);
    assign addr_inc = addr_q + ADDR_ONE;
`endif

    // The err cycle sits in IDLE but must not accept a new command.
    assign accept    = (state_q == S_IDLE) && !err_q && bus.cmd_valid;
    assign last_word = (rem_q == LEN_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = bus.cmd_wr;
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = wr_q ? S_WR_DATA : S_RD_MEM;
                end
            end
            S_WR_DATA: begin
                if (bus.wd_valid) begin
                    wdata_d = bus.wd_data;
                    state_d = S_WR_MEM;
                end
            end
            S_WR_MEM: begin
                if (bus.mem_ready) begin
                    addr_d  = addr_inc;
                    rem_d   = rem_q - LEN_ONE;
                    state_d = last_word ? S_DONE : S_WR_DATA;
                end
            end
            S_RD_MEM: begin
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    state_d = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (bus.rd_ready) begin
                    addr_d  = addr_inc;
                    rem_d   = rem_q - LEN_ONE;
                    state_d = last_word ? S_DONE : S_RD_MEM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wd_ready  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.done      = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wr_rd = 1'b0;
        bus.err       = err_q;
        bus.rd_data   = rdata_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        unique case (state_q)
            S_IDLE:    bus.cmd_ready = !err_q;
            S_WR_DATA: bus.wd_ready  = 1'b1;
            S_WR_MEM: begin
                bus.mem_valid = 1'b1;
                bus.mem_wr_rd = 1'b1;
            end
            S_RD_MEM:  bus.mem_valid = 1'b1;
            S_RD_OUT:  bus.rd_valid  = 1'b1;
            S_DONE:    bus.done      = 1'b1;
            default: begin
                bus.cmd_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst master that sits directly upstream of the single-port `memory` block and drives its `valid`/`ready` request interface. It accepts one burst command at a time (start address, length, direction) and converts it into a sequence of single-word memory transactions. Write data comes from an upstream stream port, and read data goes out on a downstream stream port. Its job is to take the per-word handshake sequencing that benches currently do by hand and move it into RTL.

## Interface
- `WIDTH`, 8, data word width; must equal the memory's `WIDTH`
- `DEPTH`, 16, memory depth in words; must equal the memory's `DEPTH`
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  burst command present
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_WIDTH  start address
- `cmd_len`  in  ADDR_WIDTH+1  word count, legal range 1..DEPTH
- `wd_valid` / `wd_ready`  in / out  1  write-data stream handshake
- `wd_data`  in  WIDTH  write word
- `rd_valid` / `rd_ready`  out / in  1  read-data stream handshake
- `rd_data`  out  WIDTH  read word
- `done`  out  1  one-cycle pulse when a burst completes
- `err`  out  1  one-cycle pulse when a command is rejected
- `mem_valid`, `mem_wr_rd`  out  1  memory request and direction (1 = write)
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory read data
- `mem_ready`  in  1  memory completion

## Operation
**FSM states:** IDLE, CHECK, WR_DATA, WR_MEM, RD_MEM, RD_OUT, DONE.

**IDLE**
- `cmd_ready = 1`.
- On command handshake: latch `cmd_wr`, `cmd_addr` and `cmd_len` into the working registers `cur_addr` and `remaining`, then go to CHECK.

**CHECK** (1 cycle)
- Reject if `cmd_len == 0`.
- Without the macro, also reject if `cmd_addr + cmd_len > DEPTH`. Evaluate this sum at ADDR_WIDTH+2 bits; no truncation is allowed.
- On reject: pulse `err`, go to IDLE, and perform no memory access.
- Otherwise go to WR_DATA (write burst) or RD_MEM (read burst).

**WR_DATA**
- `wd_ready = 1`.
- On a `wd` handshake, capture `wd_data` into `mem_wdata` and go to WR_MEM.

**WR_MEM**
- Drive `mem_valid = 1`, `mem_wr_rd = 1`, `mem_addr = cur_addr`.
- Hold all of these stable until `mem_ready` is sampled high.
- Then increment `cur_addr`, decrement `remaining`, and go to WR_DATA, or to DONE if `remaining` was 1.

**RD_MEM**
- Drive `mem_valid = 1`, `mem_wr_rd = 0`, `mem_addr = cur_addr`.
- On the edge where `mem_ready` is sampled high, register `mem_rdata` into `rd_data` and go to RD_OUT.

**RD_OUT**
- `rd_valid = 1`.
- Hold `rd_data` until `rd_ready` is sampled high.
- Then advance the address and count, and go to RD_MEM or DONE.

**DONE**
- Pulse `done` for 1 cycle, then go to IDLE.

**General rules**
- At most one memory transaction is outstanding.
- `mem_valid` is never asserted in IDLE, CHECK, WR_DATA, RD_OUT or DONE.
- Address increment is modulo 2^ADDR_WIDTH.

## Timing
- **Reset values:** every output is 0 except `cmd_ready`, which is 1 (FSM in IDLE).
- **Reset mid-burst:**
  - Asynchronous return to IDLE; the burst is abandoned.
  - `mem_valid` drops immediately.
  - A pending `rd_data` is discarded.
- **Command to first memory request:** the first `mem_valid` rises 2 cycles after the command handshake for a read. For a write, it rises 1 cycle after the first `wd` handshake, which is accepted no earlier than 2 cycles after the command.
- **Per-word cost:**
  - Write: ≥ 2 cycles (data handshake, then memory handshake).
  - Read: ≥ 2 cycles (memory handshake, then output handshake).
- **`done`** asserts the cycle after the final memory handshake (write) or the final `rd` handshake (read).
- **Back-to-back commands:** a new command may be accepted no earlier than the cycle after `done` or `err`.
- **Idle strobes:** `wd_valid` asserted outside WR_DATA is ignored (`wd_ready = 0`). `rd_ready` asserted while `rd_valid = 0` has no effect.

## Configuration
- **`MEM_BURST_WRAP_EN` defined:** CHECK does not perform the overflow check; only `cmd_len == 0` is rejected. Addresses wrap modulo DEPTH, so the word after DEPTH-1 goes to address 0.
- **Not defined:** a burst crossing DEPTH-1 is rejected with `err`, and no memory access occurs.

## Test plan
- **Single write then read:** write burst `addr=15`, `len=1`, `wd_data=8'hA5` -> one `mem_valid`, `mem_wr_rd=1`, `mem_addr=15`, `mem_wdata=A5`, then `done`. Read burst `addr=15`, `len=1` -> `rd_data=A5`, then `done`.
- **Full-depth sweep:** write `addr=0`, `len=16` with data 100..115, then read `addr=0`, `len=16` -> `rd` stream 100..115 in order, exactly 16 memory handshakes each way.
- **Backpressure:** read `len=5` with `rd_ready` low for 3 cycles per word and `mem_ready` delayed 2 cycles -> `rd_data` held stable, no word dropped or duplicated, `mem_addr` stable while `mem_valid` is high.
- **Overflow:** command `addr=12`, `len=8`. Macro off -> `err` pulse and zero `mem_valid` cycles. Macro on -> addresses 12,13,14,15,0,1,2,3.
- **Illegal length:** `cmd_len=0` -> `err` pulse 2 cycles after the handshake, `cmd_ready` back high the next cycle.
- **Reset mid-burst:** assert `rst` during the third word of a `len=8` write -> all outputs at reset values immediately. A subsequent `len=1` write to `addr=3` completes normally.
